mio_bus_sequencer: RTL

Multi-cycle sequencer for the shared memory/IO bus behind the single-cycle CPU. It turns the decoder's MemRead/MemWrite into a bus transaction with a MIO_ready handshake, and stalls the CPU until the access completes. It arbitrates the bus round-robin between the CPU data port and one read-only device requester (display/DMA reader). It drives CPU_MIO to flag CPU bus ownership and times out accesses that are never acknowledged.

---
 rtl/mio_bus_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mio_bus_sequencer.sv
// mio_bus_sequencer
// Multi-cycle sequencer for the shared memory/IO bus. It converts CPU
// MemRead/MemWrite into a strobe/MIO_ready handshake and stalls the CPU until
// the access completes. The bus is shared round-robin with a read-only device
// requester. Accesses that are never acknowledged are aborted after TIMEOUT
// cycles with zero read data and a sticky bus_err flag.
module mio_bus_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU data port
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // Device read port
    input  logic              dev_req,
    input  logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_ack,
    // Shared bus
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rd,
    output logic              bus_wr,
    input  logic              MIO_ready,
    output logic              CPU_MIO,
    output logic              bus_err
);

    // Counter wide enough to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Abort fires on the last permitted wait cycle, so an access spends
    // exactly TIMEOUT cycles in its ACC state before being forced to DONE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_ACC  = 3'd1,
        ST_CPU_DONE = 3'd2,
        ST_DEV_ACC  = 3'd3,
        ST_DEV_DONE = 3'd4
    } state_e;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DEV = 1'b1;

    state_e              state_q;
    logic                last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                acc_rd_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                bus_rd_q;
    logic                bus_wr_q;
    logic                cpu_mio_q;
    logic                dev_ack_q;
    logic                bus_err_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dev_rdata_q;

    logic                cpu_req_s;
    logic                grant_cpu_s;

    assign cpu_req_s   = cpu_rd | cpu_wr;
    // On a tie the requester that was not served last wins.
    assign grant_cpu_s = cpu_req_s & (~dev_req | (last_grant_q == GRANT_DEV));

    // Sequencer FSM with registered bus strobes, ownership flag and handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_DEV;
            cnt_q        <= '0;
            acc_rd_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_rd_q     <= 1'b0;
            bus_wr_q     <= 1'b0;
            cpu_mio_q    <= 1'b0;
            dev_ack_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dev_rdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_cpu_s) begin
                        state_q     <= ST_CPU_ACC;
                        bus_addr_q  <= cpu_addr;
                        bus_wdata_q <= cpu_wdata;
                        acc_rd_q    <= cpu_rd;
                        bus_rd_q    <= cpu_rd;
                        bus_wr_q    <= cpu_wr;
                        cpu_mio_q   <= 1'b1;
                        cnt_q       <= '0;
                    end else if (dev_req) begin
                        state_q     <= ST_DEV_ACC;
                        bus_addr_q  <= dev_addr;
                        bus_wdata_q <= '0;
                        acc_rd_q    <= 1'b1;
                        bus_rd_q    <= 1'b1;
                        bus_wr_q    <= 1'b0;
                        cpu_mio_q   <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_CPU_ACC: begin
                    if (MIO_ready) begin
                        // Stores leave the load-data register untouched.
                        if (acc_rd_q) begin
                            cpu_rdata_q <= bus_rdata;
                        end else begin
                            cpu_rdata_q <= cpu_rdata_q;
                        end
                        bus_rd_q <= 1'b0;
                        bus_wr_q <= 1'b0;
                        state_q  <= ST_CPU_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        cpu_rdata_q <= '0;
                        bus_err_q   <= 1'b1;
                        bus_rd_q    <= 1'b0;
                        bus_wr_q    <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        state_q     <= ST_CPU_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CPU_DONE: begin
                    // CPU commits on this edge; ownership is released.
                    cpu_mio_q    <= 1'b0;
                    last_grant_q <= GRANT_CPU;
                    state_q      <= ST_IDLE;
                end
                ST_DEV_ACC: begin
                    if (MIO_ready) begin
                        dev_rdata_q <= bus_rdata;
                        bus_rd_q    <= 1'b0;
                        dev_ack_q   <= 1'b1;
                        state_q     <= ST_DEV_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        dev_rdata_q <= '0;
                        bus_err_q   <= 1'b1;
                        bus_rd_q    <= 1'b0;
                        dev_ack_q   <= 1'b1;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        state_q     <= ST_DEV_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DEV_DONE: begin
                    dev_ack_q    <= 1'b0;
                    last_grant_q <= GRANT_DEV;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bus_rd_q  <= 1'b0;
                    bus_wr_q  <= 1'b0;
                    cpu_mio_q <= 1'b0;
                    dev_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so a fresh CPU request freezes the PC in its
    // first cycle; it is released only in CPU_DONE and forced low in reset.
    assign cpu_stall = rst_n & cpu_req_s & (state_q != ST_CPU_DONE);

    assign cpu_rdata = cpu_rdata_q;
    assign dev_rdata = dev_rdata_q;
    assign dev_ack   = dev_ack_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wr    = bus_wr_q;
    assign CPU_MIO   = cpu_mio_q;
    assign bus_err   = bus_err_q;

endmodule
